// File: rtl/cmp_binary_search.sv
// Recovers the unknown B operand of a magnitude comparator by binary search on A,
// in unsigned or two's-complement mode, reporting the value and the number of probes.
module cmp_binary_search #(
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 0,
  localparam int PW     = $clog2(WIDTH + 2)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] cmp_a_o,
  output logic             cmp_c_o,
  input  logic [2:0]       cmp_f_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] result_o,
  output logic [PW-1:0]    probes_o
);

  // Two spare bits keep lo/hi/mid and mid+/-1 clear of wrap-around in both modes.
  localparam int IW = WIDTH + 2;
  localparam int CW = $clog2(CMP_LAT + 2);

  localparam logic signed [IW-1:0] SignedLo   = {3'b111, {(WIDTH-1){1'b0}}};
  localparam logic signed [IW-1:0] SignedHi   = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] UnsignedLo = '0;
  localparam logic signed [IW-1:0] UnsignedHi = {2'b00, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, PROBE, WAIT, EVAL} state_t;

  state_t               state_q;
  logic signed [IW-1:0] lo_q, hi_q, mid_q;
  logic signed [IW-1:0] lo_d, hi_d, mid_d;
  logic        [IW:0]   sum;
  logic        [CW-1:0] waitCnt_q;

  // Floor midpoint: sign-extend, add, then drop the LSB.
  always_comb begin
    sum   = {lo_q[IW-1], lo_q} + {hi_q[IW-1], hi_q};
    mid_d = sum[IW:1];
    lo_d  = lo_q;
    hi_d  = hi_q;
    if (cmp_f_i == 3'b100) begin
      hi_d = mid_q - IW'(1);
    end else if (cmp_f_i == 3'b001) begin
      lo_d = mid_q + IW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      mid_q     <= '0;
      waitCnt_q <= '0;
      cmp_a_o   <= '0;
      cmp_c_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      result_o  <= '0;
      probes_o  <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cmp_c_o  <= mode_i;
            lo_q     <= mode_i ? SignedLo : UnsignedLo;
            hi_q     <= mode_i ? SignedHi : UnsignedHi;
            probes_o <= '0;
            busy_o   <= 1'b1;
            state_q  <= PROBE;
          end
        end
        PROBE: begin
          mid_q    <= mid_d;
          cmp_a_o  <= mid_d[WIDTH-1:0];
          probes_o <= probes_o + PW'(1);
          if (CMP_LAT > 0) begin
            waitCnt_q <= '0;
            state_q   <= WAIT;
          end else begin
            state_q <= EVAL;
          end
        end
        WAIT: begin
          if (waitCnt_q == CW'(CMP_LAT - 1)) begin
            state_q <= EVAL;
          end else begin
            waitCnt_q <= waitCnt_q + CW'(1);
          end
        end
        EVAL: begin
          if (cmp_f_i == 3'b010) begin
            result_o <= cmp_a_o;
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            state_q  <= IDLE;
          end else if (cmp_f_i == 3'b100 || cmp_f_i == 3'b001) begin
            lo_q <= lo_d;
            hi_q <= hi_d;
            if (lo_d > hi_d) begin
              err_o   <= 1'b1;
              busy_o  <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= PROBE;
            end
          end else begin
            // A flag pattern that is not one-hot means the comparator cannot be trusted.
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
